// File: rtl/lc3b_mem_pkg.sv
// Shared definitions for the LC-3b memory-stage access controller:
// memory op encoding, access-controller FSM states and datapath widths.
package lc3b_mem_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        MEM_LDW = 2'b00,
        MEM_LDB = 2'b01,
        MEM_STW = 2'b10,
        MEM_STB = 2'b11
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ISSUE   = 2'b01,
        CAPTURE = 2'b10,
        RESP    = 2'b11
    } mau_state_e;

    // Loads are the ops with a clear top encoding bit.
    function automatic logic op_is_load(input logic [1:0] op);
        return ~op[1];
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational byte-lane steering for the memory-stage access controller.
// Load side: word pass-through or byte lane select with sign extension.
// Store side: data replication for byte stores and write-strobe generation.
// Loads never produce strobes and stores never produce load data.
module mem_byte_lane
    import lc3b_mem_pkg::*;
(
    input  logic [1:0]        op,
    input  logic              byte_sel,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic [DATA_W-1:0] load_word,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] store_data,
    output logic              we_low,
    output logic              we_hi
);

    logic [7:0] lane;

    // Steer load/store data and strobes according to the op and the byte address bit.
    always_comb begin
        load_data  = '0;
        store_data = '0;
        we_low     = 1'b0;
        we_hi      = 1'b0;
        lane       = byte_sel ? load_word[15:8] : load_word[7:0];
        case (op)
            MEM_LDW: load_data = load_word;
            MEM_LDB: load_data = {{8{lane[7]}}, lane};
            MEM_STW: begin
                store_data = store_data_in;
                we_low     = 1'b1;
                we_hi      = 1'b1;
            end
            MEM_STB: begin
                store_data = {store_data_in[7:0], store_data_in[7:0]};
                we_hi      = byte_sel;
                we_low     = ~byte_sel;
            end
            default: begin
                load_data  = '0;
                store_data = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access controller for the LC-3b pipeline. Accepts one
// load/store at a time, drives port 2 of the shared block RAM (one-cycle
// synchronous read latency) and returns results over a valid/ready handshake.
// Optional feature macro: MEM_ALIGN_CHECK_EN -- word ops with an odd address
// make no memory access and complete with err_unaligned set.
module mem_access_unit
    import lc3b_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_dest,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we_low,
    output logic              mem_we_hi,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [2:0]        resp_dest,
    output logic              resp_is_load,
    output logic              err_unaligned
);

    mau_state_e        state_q, state_d;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        dest_q;
    logic [DATA_W-1:0] resp_data_q;
    logic [2:0]        resp_dest_q;
    logic              resp_is_load_q;
    logic              resp_err_q;
    logic              accept;
    logic              unaligned;
    logic [DATA_W-1:0] lane_load_data;
    logic [DATA_W-1:0] lane_store_data;
    logic              lane_we_low;
    logic              lane_we_hi;

`ifdef MEM_ALIGN_CHECK_EN
    assign unaligned = ~op_q[0] & addr_q[0];
`else
    assign unaligned = 1'b0;
`endif

    mem_byte_lane u_byte_lane (
        .op            (op_q),
        .byte_sel      (addr_q[0]),
        .store_data_in (wdata_q),
        .load_word     (mem_rdata),
        .load_data     (lane_load_data),
        .store_data    (lane_store_data),
        .we_low        (lane_we_low),
        .we_hi         (lane_we_hi)
    );

    // The memory always sees the word-aligned address of the held request.
    assign mem_addr      = {addr_q[ADDR_W-1:1], 1'b0};
    assign mem_wdata     = lane_store_data;
    assign resp_data     = resp_data_q;
    assign resp_dest     = resp_dest_q;
    assign resp_is_load  = resp_is_load_q;
    assign err_unaligned = resp_err_q;

    // State register; reset abandons any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state, handshake and strobe decode; strobes only exist in ISSUE.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we_low = 1'b0;
        mem_we_hi  = 1'b0;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = rst_n;
                accept    = req_valid & req_ready;
                if (accept) state_d = ISSUE;
            end
            ISSUE: begin
                mem_we_low = lane_we_low & ~unaligned;
                mem_we_hi  = lane_we_hi & ~unaligned;
                state_d    = CAPTURE;
            end
            CAPTURE: state_d = RESP;
            RESP: begin
                resp_valid = 1'b1;
                req_ready  = rst_n & resp_ready;
                accept     = req_valid & req_ready;
                if (resp_ready) state_d = accept ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Hold the accepted request for the ISSUE and CAPTURE cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            dest_q  <= '0;
        end else if (accept) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            dest_q  <= req_dest;
        end
    end

    // Capture the response once read data is valid; it stays put through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_data_q    <= '0;
            resp_dest_q    <= '0;
            resp_is_load_q <= 1'b0;
            resp_err_q     <= 1'b0;
        end else if (state_q == CAPTURE) begin
            resp_data_q    <= (op_is_load(op_q) && !unaligned) ? lane_load_data : '0;
            resp_dest_q    <= dest_q;
            resp_is_load_q <= op_is_load(op_q);
            resp_err_q     <= unaligned;
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access controller for the LC-3b pipeline. It accepts one load or store request at a time from the execute stage and drives the read/write data port (port 2) of the shared 2-port block-RAM memory. It handles byte lanes, sign extension and the memory's one-cycle synchronous read latency, and returns results to writeback over a valid/ready handshake. The top level ties the memory enable high, so this block never gates it.

## Interface
- ADDR_W, 16, byte-address width
- DATA_W, 16, word width; only 16 is supported
- clk  in  1  rising-edge clock, shared with memory
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted on the edge where valid&&ready
- req_op  in  2  MEM_LDW / MEM_LDB / MEM_STW / MEM_STB
- req_addr  in  16  byte address
- req_wdata  in  16  store data; STB uses bits [7:0]
- req_dest  in  3  destination register tag, passed through
- mem_addr  out  16  to memory addr2
- mem_we_low, mem_we_hi  out  1 each  to memory weLow/weHi
- mem_wdata  out  16  to memory dataIn
- mem_rdata  in  16  from memory dataOut2
- resp_valid  out  1  result present
- resp_ready  in  1  writeback accepts
- resp_data  out  16  load result; 0 for stores
- resp_dest  out  3  tag of the completed request
- resp_is_load  out  1  1 for LDW/LDB
- err_unaligned  out  1  valid with resp_valid (see Configuration)

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: req_ready=1. On accept, register op, addr, wdata and dest, then go to ISSUE.
- ISSUE (exactly one cycle): drive mem_addr and the write strobes, then go to CAPTURE.
- CAPTURE: register the extracted mem_rdata into resp_data, then go to RESP.
- RESP: resp_valid=1 and all resp_* fields are held stable. On resp_ready, go to IDLE, or go directly to ISSUE if a new request is accepted in the same cycle.
- req_ready = (state==IDLE) || (state==RESP && resp_ready).
- Word ops: mem_addr = {addr[15:1],1'b0}.
  - LDW: resp_data = mem_rdata.
  - STW: both strobes on, mem_wdata = wdata.
- Byte ops: mem_addr = {addr[15:1],1'b0}.
  - LDB: lane = addr[0] ? rdata[15:8] : rdata[7:0], sign-extended to 16 bits.
  - STB: mem_wdata = {wdata[7:0],wdata[7:0]}, mem_we_hi = addr[0], mem_we_low = ~addr[0].
- Strobes are 0 in every state except ISSUE, and are never asserted for loads.
- Stores still traverse CAPTURE and RESP so that every op has uniform latency; for stores resp_data = 0 and resp_is_load = 0.
- Reset values: state IDLE, all outputs 0, except req_ready = 1 once rst_n is high.
- Asserting rst_n mid-operation abandons the request. Strobes drop asynchronously, so no partial write occurs after reset assertion. A write already committed at an earlier edge stands.

## Timing
- Request accepted at edge T.
- mem_addr and strobes are valid during T..T+1. Memory samples at edge T+1, and a store is committed there.
- mem_rdata is valid after T+1. It is captured at edge T+2, and resp_valid rises after T+2.
- Accept-to-response latency is 2 cycles.
- Peak throughput is one request per 3 cycles, using the RESP→ISSUE bypass.
- A load following a store to the same address sees the new data, because the write commits before the load's ISSUE.
- resp_valid never drops without resp_ready.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - LDW or STW with addr[0]=1 performs no memory access; the strobes stay 0.
  - The request still takes the normal latency and returns resp_data=0 with err_unaligned=1.
- MEM_ALIGN_CHECK_EN undefined: addr[0] is ignored for word ops, and err_unaligned is tied 0.

## Structure
- The shared package lc3b_mem_pkg holds:
  - the op encoding (MEM_LDW=2'b00, MEM_LDB=2'b01, MEM_STW=2'b10, MEM_STB=2'b11);
  - the FSM state enum;
  - the ADDR_W and DATA_W constants.
- One sub-module, mem_byte_lane, is combinational. It performs load lane select and sign extension, plus store replication and strobe generation, and is shared by the ISSUE and CAPTURE paths.

## Test plan
The memory power-up pattern stores its own even byte address in each word.
- LDW 0x1234 -> resp_data 0x1234 at accept+2, resp_is_load=1, dest echoed.
- LDB 0x80F1 -> 0xFF80; LDB 0x1235 -> 0x0012; LDB 0x1234 -> 0x0034.
- STB 0x2001 with wdata 0x00AB -> mem_we_hi pulses for exactly 1 cycle. A following LDW 0x2000 -> 0xAB00.
- Hold resp_ready=0 for 5 cycles with req_valid=1 -> response stable, req_ready=0, no second access. Release -> next request enters ISSUE on the same edge.
- With MEM_ALIGN_CHECK_EN, STW 0x3001 -> no strobes, err_unaligned=1. A following LDW 0x3000 -> 0x3000.
- Drop rst_n during ISSUE of STW 0x4000 -> strobes drop immediately, and a following LDW 0x4000 -> 0x4000.
